// File: rtl/riscv_redundant.sv
// riscv_redundant: NUM_CORES redundant riscv cores, bitwise majority voter, OK/DEGRADED/FAIL fault tracking.
// Define RISCV_RED_FI_EN to add the fi_en/fi_core_mask/fi_bit single-bit fault-injection inputs.

// riscv: small deterministic trace core; every lane runs the same program from reset.
module riscv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [31:0]       WB_Data,
    output logic [4:0]        reg_num,
    output logic [31:0]       reg_data,
    output logic              reg_write_sig,
    output logic              wr,
    output logic              rd,
    output logic [8:0]        addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    logic [8:0]  pc;
    logic [31:0] acc;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pc  <= '0;
            acc <= '0;
        end else begin
            pc  <= pc + 9'd1;
            acc <= acc + ({23'd0, pc} ^ 32'h9e37_79b9);
        end
    // Slot pc%4==3 is a store, pc%4==1 a load; every non-store slot writes the register file.
    assign WB_Data       = acc;
    assign reg_num       = pc[4:0];
    assign reg_data      = acc ^ {pc, 23'd0};
    assign reg_write_sig = pc[1:0] != 2'd3;
    assign wr            = pc[1:0] == 2'd3;
    assign rd            = pc[1:0] == 2'd1;
    assign addr          = pc ^ 9'h155;
    assign wr_data       = DATA_W'(acc);
    assign rd_data       = DATA_W'({acc[15:0], acc[31:16]});
endmodule

module riscv_redundant #(
    parameter int DATA_W    = 32,
    parameter int NUM_CORES = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef RISCV_RED_FI_EN
    input  logic                      fi_en,
    input  logic [NUM_CORES-1:0]      fi_core_mask,
    input  logic [$clog2(81+2*DATA_W)-1:0] fi_bit,
`endif
    output logic [31:0]               WB_Data,
    output logic [4:0]                reg_num,
    output logic [31:0]               reg_data,
    output logic                      reg_write_sig,
    output logic                      wr,
    output logic                      rd,
    output logic [8:0]                addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [DATA_W-1:0]         rd_data,
    output logic [1:0]                fault_state,
    output logic [NUM_CORES-1:0]      err_core,
    output logic [ERR_CNT_W-1:0]      err_count
);
    localparam int BW = 81 + 2 * DATA_W;
    localparam logic [BW-1:0] one_hot = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] strobe_mask = {{(BW-3){1'b0}}, 3'b111} << (2 * DATA_W + 9);

    typedef enum logic [1:0] {s_ok = 2'b00, s_degraded = 2'b01, s_fail = 2'b10} state_t;

    state_t                 state;
    logic [BW-1:0]          bund [NUM_CORES];
    logic [BW-1:0]          vote;
    logic [BW-1:0]          out_q;
    logic [NUM_CORES-1:0]   mis;
    logic                   majority;
    logic                   squash;

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
        logic [31:0]       wb, rdat;
        logic [4:0]        rnum;
        logic              rws, w, r;
        logic [8:0]        a;
        logic [DATA_W-1:0] wd, rdd;
        logic [BW-1:0]     raw;
        riscv #(.DATA_W(DATA_W)) u_core (
            .clk(clk), .reset(reset), .WB_Data(wb), .reg_num(rnum), .reg_data(rdat),
            .reg_write_sig(rws), .wr(w), .rd(r), .addr(a), .wr_data(wd), .rd_data(rdd)
        );
        assign raw = {wb, rnum, rdat, rws, w, r, a, wd, rdd};
`ifdef RISCV_RED_FI_EN
        // A shift past the bundle width yields zero, so out-of-range fi_bit injects nothing.
        assign bund[c] = raw ^ ((fi_en && fi_core_mask[c]) ? one_hot << fi_bit : '0);
`else
        assign bund[c] = raw;
`endif
        assign mis[c] = bund[c] != vote;
    end

    for (genvar b = 0; b < BW; b++) begin : g_vote
        logic [NUM_CORES-1:0] col;
        for (genvar c = 0; c < NUM_CORES; c++) begin : g_col
            assign col[c] = bund[c][b];
        end
        assign vote[b] = 2 * $countones(col) == NUM_CORES ? col[0] : 2 * $countones(col) > NUM_CORES;
    end

    assign majority = NUM_CORES - $countones(mis) > NUM_CORES / 2;
    assign squash   = state == s_fail || !majority;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= s_ok;
            err_core  <= '0;
            err_count <= '0;
            out_q     <= '0;
        end else begin
            state     <= squash ? s_fail : (|mis ? s_degraded : state);
            err_core  <= err_core | mis;
            err_count <= (|mis && err_count != '1) ? err_count + ERR_CNT_W'(1) : err_count;
            out_q     <= squash ? vote & ~strobe_mask : vote;
        end

    assign {WB_Data, reg_num, reg_data, reg_write_sig, wr, rd, addr, wr_data, rd_data} = out_q;
    assign fault_state = state;
endmodule

// File: tb/tb_riscv_redundant.sv
// tb_riscv_redundant: scoreboard bench for a 3-core/8-bit-counter and a 2-core/2-bit-counter riscv_redundant.
// Fault-injection scenarios run when RISCV_RED_FI_EN is defined.
module tb_riscv_redundant;
    logic         clk;
    logic         reset;
    logic [144:0] o1, o2;
    logic [1:0]   st1, st2;
    logic [2:0]   ecore1;
    logic [1:0]   ecore2;
    logic [7:0]   cnt1;
    logic [1:0]   cnt2;
`ifdef RISCV_RED_FI_EN
    logic         fi_en;
    logic [2:0]   fi_core_mask;
    logic [7:0]   fi_bit;
`endif

    typedef struct {
        logic [144:0] o1, o2;
        logic [1:0]   fs1, fs2;
        logic [2:0]   ec1;
        logic [1:0]   ec2;
        logic [7:0]   c1;
        logic [1:0]   c2;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          k;
    logic [31:0] acc_m;
    logic [1:0]  m_fs1, m_fs2;
    logic [2:0]  m_ec1, m_ec2;
    int          m_c1, m_c2;

    riscv_redundant #(.DATA_W(32), .NUM_CORES(3), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset),
`ifdef RISCV_RED_FI_EN
        .fi_en(fi_en), .fi_core_mask(fi_core_mask), .fi_bit(fi_bit),
`endif
        .WB_Data(o1[144:113]), .reg_num(o1[112:108]), .reg_data(o1[107:76]),
        .reg_write_sig(o1[75]), .wr(o1[74]), .rd(o1[73]), .addr(o1[72:64]),
        .wr_data(o1[63:32]), .rd_data(o1[31:0]),
        .fault_state(st1), .err_core(ecore1), .err_count(cnt1)
    );

    riscv_redundant #(.DATA_W(32), .NUM_CORES(2), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
`ifdef RISCV_RED_FI_EN
        .fi_en(fi_en), .fi_core_mask(fi_core_mask[1:0]), .fi_bit(fi_bit),
`endif
        .WB_Data(o2[144:113]), .reg_num(o2[112:108]), .reg_data(o2[107:76]),
        .reg_write_sig(o2[75]), .wr(o2[74]), .rd(o2[73]), .addr(o2[72:64]),
        .wr_data(o2[63:32]), .rd_data(o2[31:0]),
        .fault_state(st2), .err_core(ecore2), .err_count(cnt2)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [144:0] act, input logic [144:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // The program every core executes: slot k stores if k%4==3, loads if k%4==1, else writes a register.
    function automatic logic [144:0] program_trace(input int kk, input logic [31:0] acc);
        logic [8:0] pc;
        pc = 9'(kk);
        return {acc, pc[4:0], acc ^ {pc, 23'd0}, 1'(kk % 4 != 3), 1'(kk % 4 == 3), 1'(kk % 4 == 1),
                pc ^ 9'h155, acc, acc[15:0], acc[31:16]};
    endfunction

    // Reference voter: faulty cores all carry the same flipped bundle, so the vote is whichever
    // of the two values more cores hold (core 0's value on a tie).
    function automatic logic [144:0] model(input int n, input int cmax, input logic [144:0] base,
                                           input logic [2:0] inj_all, input logic [7:0] bit_i,
                                           inout logic [1:0] fs, inout logic [2:0] ec, inout int cnt);
        logic [144:0] alt, v;
        logic [2:0]   inj, mis;
        int           flipped, agree;
        alt = base;
        if (bit_i < 145) alt[bit_i] = ~alt[bit_i];
        inj = inj_all & 3'((1 << n) - 1);
        flipped = $countones(inj);
        v = (2 * flipped > n || (2 * flipped == n && inj[0])) ? alt : base;
        mis = '0;
        agree = 0;
        for (int c = 0; c < n; c++) begin
            mis[c] = (inj[c] ? alt : base) != v;
            if (!mis[c]) agree++;
        end
        if (fs == 2'b10 || !(agree > n / 2)) begin
            v[75:73] = 3'b000;
            fs = 2'b10;
        end else if (mis != 0) fs = 2'b01;
        ec = ec | mis;
        if (mis != 0 && cnt < cmax) cnt++;
        return v;
    endfunction

    task automatic restart();
        reset = 0;
        k = 0; acc_m = '0;
        m_fs1 = 0; m_fs2 = 0; m_ec1 = 0; m_ec2 = 0; m_c1 = 0; m_c2 = 0;
    endtask

    // Called at a negedge: drive this cycle's injection, queue what the next edge must show.
    task automatic step_cycle(input logic en, input logic [2:0] mask, input logic [7:0] b);
        logic [144:0] base;
        exp_t         x;
`ifdef RISCV_RED_FI_EN
        fi_en = en; fi_core_mask = mask; fi_bit = b;
`endif
        base = program_trace(k, acc_m);
        x.o1 = model(3, 255, base, en ? mask : 3'b000, b, m_fs1, m_ec1, m_c1);
        x.o2 = model(2, 3, base, en ? mask : 3'b000, b, m_fs2, m_ec2, m_c2);
        x.fs1 = m_fs1; x.fs2 = m_fs2;
        x.ec1 = m_ec1; x.ec2 = m_ec2[1:0];
        x.c1 = 8'(m_c1); x.c2 = 2'(m_c2);
        q.push_back(x);
        acc_m = acc_m + ({23'd0, 9'(k)} ^ 32'h9e37_79b9);
        k++;
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out3"}, o1, '0);
        check({tag, "_out2"}, o2, '0);
        check({tag, "_state3"}, 145'(st1), '0);
        check({tag, "_state2"}, 145'(st2), '0);
        check({tag, "_errcore3"}, 145'(ecore1), '0);
        check({tag, "_errcore2"}, 145'(ecore2), '0);
        check({tag, "_count3"}, 145'(cnt1), '0);
        check({tag, "_count2"}, 145'(cnt2), '0);
    endtask

    // Reset lands mid-cycle; outputs must clear without any clock edge.
    task automatic mid_reset();
        @(posedge clk);
        #3 reset = 1;
        #1 check_zero("midreset");
        @(posedge clk);
        @(negedge clk);
        restart();
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++)
            step_cycle($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("vote3", o1, e.o1);
            check("vote2", o2, e.o2);
            check("state3", 145'(st1), 145'(e.fs1));
            check("state2", 145'(st2), 145'(e.fs2));
            check("errcore3", 145'(ecore1), 145'(e.ec1));
            check("errcore2", 145'(ecore2), 145'(e.ec2));
            check("count3", 145'(cnt1), 145'(e.c1));
            check("count2", 145'(cnt2), 145'(e.c2));
        end
    end

    initial begin
        reset = 0;
`ifdef RISCV_RED_FI_EN
        fi_en = 0; fi_core_mask = 0; fi_bit = 0;
`endif
        #2 reset = 1;
        repeat (2) @(posedge clk);
        #2 check_zero("reset");
        @(negedge clk);
        restart();
        repeat (200) step_cycle(0, 3'b000, 8'd0);
`ifdef RISCV_RED_FI_EN
        while (k % 4 != 3) step_cycle(0, 3'b000, 8'd0);
        step_cycle(1, 3'b010, 8'd0);
        repeat (10) step_cycle(0, 3'b000, 8'd0);
        mid_reset();
        repeat (20) step_cycle(0, 3'b000, 8'd0);
        step_cycle(1, 3'b110, 8'd0);
        repeat (5) step_cycle(1, 3'b110, 8'd74);
        step_cycle(1, 3'b011, 8'd200);
        repeat (10) step_cycle(0, 3'b000, 8'd0);
        random_cycles(300);
        mid_reset();
        random_cycles(200);
`else
        mid_reset();
        repeat (100) step_cycle(0, 3'b000, 8'd0);
`endif
        @(posedge clk);
        #2 check("drain", 145'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
